// File: rtl/auth_responder_if.sv
// rtl/auth_responder_if.sv - byte-stream and status bundle between the UART cores and auth_responder
interface auth_responder_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       busy;
  logic       resp_done;
  logic       frame_err;

  modport master (
    output rx_data, rx_data_valid, tx_busy,
    input  tx_data, tx_data_valid, busy, resp_done, frame_err
  );

  modport slave (
    input  rx_data, rx_data_valid, tx_busy,
    output tx_data, tx_data_valid, busy, resp_done, frame_err
  );
endinterface

// File: rtl/auth_responder.sv
// rtl/auth_responder.sv - parses CHAL:<32 hex>\n, answers RESP:<(chal^KEY)+KEY>\n over uart_tx
// Define AUTH_RESP_LC_HEX_EN to also accept lowercase a-f in the challenge digits.
module auth_responder #(
  parameter logic [127:0] SECRET_KEY     = 128'hDEAD_BEEF_CAFE_BABE_1337_C0DE_FACE_FEED,
  parameter logic [25:0]  TIMEOUT_CYCLES = 26'd12_000_000
) (
  input  logic              clk,
  input  logic              rst,
  auth_responder_if.slave   bus
);

  typedef enum logic [2:0] {
    S_HUNT, S_DIGITS, S_EOL, S_CALC, S_ISSUE, S_WAIT_HI, S_WAIT_LO
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    hunt_idx_q, hunt_idx_d;
  logic [4:0]    dig_cnt_q, dig_cnt_d;
  logic [5:0]    tx_idx_q, tx_idx_d;
  logic [127:0]  chal_q, chal_d;
  logic [127:0]  resp_q, resp_d;
  logic [25:0]   idle_q, idle_d;
  logic          resp_done_q, resp_done_d;
  logic          frame_err_q, frame_err_d;
  logic          timed_out;
  logic [4:0]    digit;

  function automatic logic [7:0] hunt_char(input logic [2:0] idx);
    case (idx)
      3'd0:    hunt_char = 8'h43;
      3'd1:    hunt_char = 8'h48;
      3'd2:    hunt_char = 8'h41;
      3'd3:    hunt_char = 8'h4C;
      default: hunt_char = 8'h3A;
    endcase
  endfunction

  // {valid, value}
  function automatic logic [4:0] hex_val(input logic [7:0] b);
    hex_val = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)
      hex_val = {1'b1, b[3:0]};
    else if (b >= 8'h41 && b <= 8'h46)
      hex_val = {1'b1, b[3:0] + 4'd9};
`ifdef AUTH_RESP_LC_HEX_EN
    else if (b >= 8'h61 && b <= 8'h66)
      hex_val = {1'b1, b[3:0] + 4'd9};
`endif
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // resp_q is shifted left after every nibble, so the next nibble is always on top
  function automatic logic [7:0] tx_byte(input logic [5:0] idx, input logic [3:0] nib);
    case (idx)
      6'd0:    tx_byte = 8'h52;
      6'd1:    tx_byte = 8'h45;
      6'd2:    tx_byte = 8'h53;
      6'd3:    tx_byte = 8'h50;
      6'd4:    tx_byte = 8'h3A;
      6'd37:   tx_byte = 8'h0A;
      default: tx_byte = hex_char(nib);
    endcase
  endfunction

  assign timed_out = (idle_q >= TIMEOUT_CYCLES - 26'd1);
  assign digit     = hex_val(bus.rx_data);

  always_comb begin
    state_d       = state_q;
    hunt_idx_d    = hunt_idx_q;
    dig_cnt_d     = dig_cnt_q;
    tx_idx_d      = tx_idx_q;
    chal_d        = chal_q;
    resp_d        = resp_q;
    idle_d        = idle_q + 26'd1;
    resp_done_d   = 1'b0;
    frame_err_d   = 1'b0;
    bus.tx_data       = 8'h00;
    bus.tx_data_valid = 1'b0;

    if (bus.rx_data_valid || (state_q == S_HUNT && hunt_idx_q == 3'd0) ||
        state_q == S_CALC || state_q == S_ISSUE ||
        state_q == S_WAIT_HI || state_q == S_WAIT_LO)
      idle_d = 26'd0;

    case (state_q)
      S_HUNT: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_data == hunt_char(hunt_idx_q)) begin
            if (hunt_idx_q == 3'd4) begin
              state_d    = S_DIGITS;
              hunt_idx_d = 3'd0;
              dig_cnt_d  = 5'd0;
            end else begin
              hunt_idx_d = hunt_idx_q + 3'd1;
            end
          end else begin
            hunt_idx_d = (bus.rx_data == 8'h43) ? 3'd1 : 3'd0;
          end
        end else if (hunt_idx_q != 3'd0 && timed_out) begin
          frame_err_d = 1'b1;
          hunt_idx_d  = 3'd0;
          idle_d      = 26'd0;
        end
      end
      S_DIGITS: begin
        if (bus.rx_data_valid) begin
          if (digit[4]) begin
            chal_d    = {chal_q[123:0], digit[3:0]};
            dig_cnt_d = dig_cnt_q + 5'd1;
            if (dig_cnt_q == 5'd31)
              state_d = S_EOL;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
            hunt_idx_d  = (bus.rx_data == 8'h43) ? 3'd1 : 3'd0;
          end
        end else if (timed_out) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
          hunt_idx_d  = 3'd0;
          idle_d      = 26'd0;
        end
      end
      S_EOL: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_data == 8'h0A) begin
            state_d = S_CALC;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
            hunt_idx_d  = 3'd0;
          end
        end else if (timed_out) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
          hunt_idx_d  = 3'd0;
          idle_d      = 26'd0;
        end
      end
      S_CALC: begin
        resp_d   = (chal_q ^ SECRET_KEY) + SECRET_KEY;
        tx_idx_d = 6'd0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.tx_busy) begin
          bus.tx_data       = tx_byte(tx_idx_q, resp_q[127:124]);
          bus.tx_data_valid = 1'b1;
          state_d           = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.tx_busy)
          state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (tx_idx_q == 6'd37) begin
            resp_done_d = 1'b1;
            state_d     = S_HUNT;
            hunt_idx_d  = 3'd0;
          end else begin
            if (tx_idx_q >= 6'd5)
              resp_d = {resp_q[123:0], 4'h0};
            tx_idx_d = tx_idx_q + 6'd1;
            state_d  = S_ISSUE;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  assign bus.busy      = (state_q == S_CALC) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  assign bus.resp_done = resp_done_q;
  assign bus.frame_err = frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HUNT;
      hunt_idx_q  <= 3'd0;
      dig_cnt_q   <= 5'd0;
      tx_idx_q    <= 6'd0;
      chal_q      <= 128'd0;
      resp_q      <= 128'd0;
      idle_q      <= 26'd0;
      resp_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hunt_idx_q  <= hunt_idx_d;
      dig_cnt_q   <= dig_cnt_d;
      tx_idx_q    <= tx_idx_d;
      chal_q      <= chal_d;
      resp_q      <= resp_d;
      idle_q      <= idle_d;
      resp_done_q <= resp_done_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
